// File: rtl/wavegen_pkg.sv
// Shared definitions for the wavetable sequencing path: command opcodes,
// sequencer states and the bit positions of the command byte fields.
package wavegen_pkg;

    typedef enum logic [3:0] {
        OP_SET   = 4'h0,
        OP_START = 4'h1,
        OP_STOP  = 4'h2
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } seq_state_t;

    localparam int CMD_SEL_MSB = 7;
    localparam int CMD_SEL_LSB = 4;
    localparam int CMD_OP_MSB  = 3;
    localparam int CMD_OP_LSB  = 0;
    localparam int SEL_W       = 4;

    // Only SET, START and STOP are meaningful; anything else flags bad_cmd.
    function automatic logic op_is_known(input logic [3:0] op);
        return (op == OP_SET) || (op == OP_START) || (op == OP_STOP);
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Sample-rate divider: a down-counter that reloads to (selector+1)*BASE_DIV-1
// each time it reaches zero. The tick is raised while enabled and the count
// is zero, so the first enabled cycle after a clear always ticks.
module rate_divider
    import wavegen_pkg::*;
#(
    parameter int BASE_DIV = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [SEL_W-1:0] selector,
    output logic             tick
);

    localparam int CNT_W = $clog2(16 * BASE_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_val;

    assign load_val = CNT_W'((32'(selector) + 32'd1) * 32'(BASE_DIV) - 32'd1);
    assign tick     = enable && (cnt == '0);

    // Count down while enabled, reloading the period on terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == '0) begin
                cnt <= load_val;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/wave_sequencer.sv
// Wavetable sequencer: decodes command bytes, owns the wave selector, the
// table reset pulse, the sample tick (clock enable) and the read address.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | quiet: no ticks, address held at 0, waiting for SET/START
//   ST_FLUSH | mem_rst high for RST_CYCLES, commands parked in pending reg
//   ST_RUN   | divider running, one mem_en per period, address advancing
module wave_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int BASE_DIV   = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        cmd,
    input  logic              cmd_valid,
    output logic [3:0]        selector,
    output logic              mem_rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              sample_valid,
    output logic              running,
    output logic              bad_cmd
);

    import wavegen_pkg::*;

    localparam int                FL_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [FL_W-1:0]   FL_INIT   = FL_W'(RST_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    seq_state_t       state;
    logic [FL_W-1:0]  fl_cnt;
    logic             pend_valid;
    logic [3:0]       pend_op;
    logic [3:0]       pend_sel;

    logic [3:0]       cmd_sel;
    logic [3:0]       cmd_opc;
    logic             cmd_known;
    logic             eff_valid;
    logic [3:0]       eff_op;
    logic [3:0]       eff_sel;
    logic             div_tick;

    assign cmd_sel   = cmd[CMD_SEL_MSB:CMD_SEL_LSB];
    assign cmd_opc   = cmd[CMD_OP_MSB:CMD_OP_LSB];
    assign cmd_known = op_is_known(cmd_opc);

    // At the end of a flush a command arriving that very cycle beats the parked one.
    always_comb begin
        eff_valid = pend_valid;
        eff_op    = pend_op;
        eff_sel   = pend_sel;
        if (cmd_valid && cmd_known) begin
            eff_valid = 1'b1;
            eff_op    = cmd_opc;
            eff_sel   = cmd_sel;
        end
    end

    rate_divider #(
        .BASE_DIV (BASE_DIV)
    ) u_rate_divider (
        .clk      (clk),
        .rst      (rst),
        .clear    (state != ST_RUN),
        .enable   (state == ST_RUN),
        .selector (selector),
        .tick     (div_tick)
    );

    // The tick is decoded from registered state and count only, so no input path reaches it.
    assign mem_en = div_tick;

    // Sequencer FSM with registered selector, flush pulse, run flag and address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            selector   <= '0;
            mem_rst    <= 1'b0;
            mem_addr   <= '0;
            running    <= 1'b0;
            bad_cmd    <= 1'b0;
            fl_cnt     <= '0;
            pend_valid <= 1'b0;
            pend_op    <= '0;
            pend_sel   <= '0;
        end else begin
            if (cmd_valid && !cmd_known) begin
                bad_cmd <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    mem_addr <= '0;
                    if (cmd_valid && (cmd_opc == OP_SET || cmd_opc == OP_START)) begin
                        if (cmd_opc == OP_SET) begin
                            selector <= cmd_sel;
                        end
                        state   <= ST_FLUSH;
                        mem_rst <= 1'b1;
                        fl_cnt  <= FL_INIT;
                    end
                end
                ST_FLUSH: begin
                    mem_addr <= '0;
                    if (fl_cnt != '0) begin
                        fl_cnt <= fl_cnt - 1'b1;
                        if (cmd_valid && cmd_known) begin
                            pend_valid <= 1'b1;
                            pend_op    <= cmd_opc;
                            pend_sel   <= cmd_sel;
                        end
                    end else begin
                        pend_valid <= 1'b0;
                        if (eff_valid && eff_op == OP_SET) begin
                            selector <= eff_sel;
                            fl_cnt   <= FL_INIT;
                        end else if (eff_valid && eff_op == OP_STOP) begin
                            state   <= ST_IDLE;
                            mem_rst <= 1'b0;
                        end else begin
                            state   <= ST_RUN;
                            mem_rst <= 1'b0;
                            running <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cmd_valid && cmd_opc == OP_SET) begin
                        selector <= cmd_sel;
                        state    <= ST_FLUSH;
                        mem_rst  <= 1'b1;
                        running  <= 1'b0;
                        fl_cnt   <= FL_INIT;
                        mem_addr <= '0;
                    end else if (cmd_valid && cmd_opc == OP_STOP) begin
                        state    <= ST_IDLE;
                        running  <= 1'b0;
                        mem_addr <= '0;
                    end else if (div_tick) begin
                        mem_addr <= (mem_addr == ADDR_LAST) ? '0 : mem_addr + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_rst <= 1'b0;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Memory read data lands one cycle after the enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= mem_en;
        end
    end

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: directed phases from the test plan
// followed by random command traffic, all compared every cycle against a
// time-based reference model (tick = cycles since RUN start modulo period).
module tb_wave_sequencer;

    localparam int ADDR_W     = 8;
    localparam int DEPTH      = 256;
    localparam int BASE_DIV   = 16;
    localparam int RST_CYCLES = 2;

    logic              clk;
    logic              rst;
    logic [7:0]        cmd;
    logic              cmd_valid;
    logic [3:0]        selector;
    logic              mem_rst;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic              sample_valid;
    logic              running;
    logic              bad_cmd;

    wave_sequencer #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .BASE_DIV   (BASE_DIV),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd),
        .cmd_valid    (cmd_valid),
        .selector     (selector),
        .mem_rst      (mem_rst),
        .mem_addr     (mem_addr),
        .mem_en       (mem_en),
        .sample_valid (sample_valid),
        .running      (running),
        .bad_cmd      (bad_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model state: 0 idle, 1 flush, 2 run.
    int m_state;
    int m_sel;
    int m_bad;
    int m_pend_v;
    int m_pend_cmd;
    int m_flush_end;
    int m_run_start;
    int m_sv;
    int cyc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int period();
        return (m_sel + 1) * BASE_DIV;
    endfunction

    function automatic int exp_en();
        if (m_state != 2) return 0;
        return (((cyc - m_run_start) % period()) == 0) ? 1 : 0;
    endfunction

    // Address equals the number of ticks already issued in this run, modulo DEPTH.
    function automatic int exp_addr();
        if (m_state != 2) return 0;
        return (((cyc - m_run_start) + period() - 1) / period()) % DEPTH;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_sel    = 0;
        m_bad    = 0;
        m_pend_v = 0;
        m_sv     = 0;
    endtask

    task automatic enter_flush();
        m_state     = 1;
        m_flush_end = cyc + RST_CYCLES;
    endtask

    task automatic check_outputs();
        check_val("selector",     32'(selector),     m_sel);
        check_val("mem_rst",      32'(mem_rst),      (m_state == 1) ? 1 : 0);
        check_val("mem_addr",     32'(mem_addr),     exp_addr());
        check_val("mem_en",       32'(mem_en),       exp_en());
        check_val("sample_valid", 32'(sample_valid), m_sv);
        check_val("running",      32'(running),      (m_state == 2) ? 1 : 0);
        check_val("bad_cmd",      32'(bad_cmd),      m_bad);
    endtask

    task automatic model_update(input logic v, input logic [7:0] c);
        int opc;
        int sel;
        int known;
        int eo;
        int es;
        opc   = int'(c[3:0]);
        sel   = int'(c[7:4]);
        known = (v && opc <= 2) ? 1 : 0;
        m_sv  = exp_en();
        if (v && opc > 2) m_bad = 1;
        case (m_state)
            0: begin
                if (known && opc == 0) begin
                    m_sel = sel;
                    enter_flush();
                end else if (known && opc == 1) begin
                    enter_flush();
                end
            end
            1: begin
                if (cyc != m_flush_end) begin
                    if (known) begin
                        m_pend_v   = 1;
                        m_pend_cmd = int'(c);
                    end
                end else begin
                    eo = -1;
                    es = 0;
                    if (known) begin
                        eo = opc;
                        es = sel;
                    end else if (m_pend_v != 0) begin
                        eo = m_pend_cmd & 15;
                        es = m_pend_cmd >> 4;
                    end
                    m_pend_v = 0;
                    if (eo == 0) begin
                        m_sel = es;
                        enter_flush();
                    end else if (eo == 2) begin
                        m_state = 0;
                    end else begin
                        m_state     = 2;
                        m_run_start = cyc + 1;
                    end
                end
            end
            default: begin
                if (known && opc == 0) begin
                    m_sel = sel;
                    enter_flush();
                end else if (known && opc == 2) begin
                    m_state = 0;
                end
            end
        endcase
        cyc++;
    endtask

    // Called at posedge+1: check this cycle, drive this cycle's input, advance.
    task automatic step(input logic v, input logic [7:0] c);
        check_outputs();
        cmd_valid = v;
        cmd       = c;
        model_update(v, c);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'($urandom));
    endtask

    task automatic mid_reset();
        #2;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic random_cmd();
        int o;
        int sel;
        int opc;
        o   = $urandom_range(0, 9);
        sel = $urandom_range(0, 15);
        if (o < 4)      opc = 0;
        else if (o < 6) opc = 1;
        else if (o < 8) opc = 2;
        else            opc = $urandom_range(3, 15);
        step(1'b1, 8'((sel << 4) | opc));
    endtask

    initial begin
        int burst;
        int guard;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        cmd       = 8'h00;
        cmd_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // SET sel=0: 2-cycle flush, then ticks every 16 cycles.
        step(1'b1, 8'h00);
        idle(100);

        // sel=3 for more than a full table: period 64, address wraps.
        step(1'b1, 8'h30);
        idle(64 * 258 + 10);

        // STOP, then START with retained selector.
        step(1'b1, 8'h02);
        idle(10);
        step(1'b1, 8'h01);
        idle(300);

        // Two SETs during FLUSH: only the newer one is applied.
        step(1'b1, 8'h02);
        idle(3);
        step(1'b1, 8'h01);
        step(1'b1, 8'h50);
        step(1'b1, 8'h70);
        idle(128 * 4 + 10);

        // Unknown opcode in RUN.
        step(1'b1, 8'h2F);
        idle(300);

        // Reset between ticks, then nothing should happen.
        guard = 0;
        while (((cyc - m_run_start) % period()) != period() / 2 && guard < 1000) begin
            idle(1);
            guard++;
        end
        check_val("mid_period_reached", 32'(guard < 1000), 1);
        mid_reset();
        idle(600);

        // Random traffic with occasional back-to-back commands.
        burst = 0;
        for (int i = 0; i < 20000; i++) begin
            if (i == 10000) mid_reset();
            if (burst > 0) begin
                random_cmd();
                burst--;
            end else if ($urandom_range(0, 99) == 0) begin
                random_cmd();
                burst = $urandom_range(0, 2);
            end else begin
                idle(1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
